// File: rtl/nucleusrv_mem_pkg.sv
// Shared definitions for the SRAM port front end: response layout and the
// fixed geometry of the in-flight pipeline and byte addressing.
package nucleusrv_mem_pkg;

    localparam int INFLIGHT_DEPTH = 2;
    localparam int BYTE_OFFSET    = 2;
    localparam int RSP_DATA_WIDTH = 32;

    typedef struct packed {
        logic [RSP_DATA_WIDTH-1:0] rdata;
        logic                      we;
        logic                      err;
    } mem_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a push and a pop in the
// same cycle are both honoured, including when the FIFO is full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];

    // Storage carries no reset so it can map onto plain memory.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            assert (!(push && !do_push));
        end
    end

endmodule

// File: rtl/sram_port_adapter.sv
// Valid/ready front end for SRAM port 0: one macro access per request, read
// data captured at the fixed macro latency, in-order buffered responses.
module sram_port_adapter
    import nucleusrv_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WMASKS     = 4,
    parameter int ADDR_WIDTH     = 25,
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int RSP_DEPTH      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
    input  logic                      req_we,
    input  logic [NUM_WMASKS-1:0]     req_wmask,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_we,
    output logic                      rsp_err,
    output logic                      sram_csb0,
    output logic                      sram_web0,
    output logic [NUM_WMASKS-1:0]     sram_wmask0,
    output logic [ADDR_WIDTH-1:0]     sram_addr0,
    output logic [DATA_WIDTH-1:0]     sram_din0,
    input  logic [DATA_WIDTH-1:0]     sram_dout0
);

    localparam int CW = $clog2(RSP_DEPTH+1);
    localparam int IW = $clog2(INFLIGHT_DEPTH+1);
    localparam int RW = DATA_WIDTH + 2;

    logic                  fire;
    logic                  in_range;
    logic                  wr_en;
    logic                  s1_valid_reg;
    logic                  s1_we_reg;
    logic                  s1_err_reg;
    logic [IW-1:0]         inflight_count;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credits_used;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  rsp_pop;
    logic [DATA_WIDTH-1:0] cap_rdata;
    logic [RW-1:0]         push_data;
    logic [RW-1:0]         head;
    logic                  unused_bits;

    generate
        if (BUS_ADDR_WIDTH > ADDR_WIDTH + BYTE_OFFSET) begin : g_range
            assign in_range = (req_addr[BUS_ADDR_WIDTH-1:ADDR_WIDTH+BYTE_OFFSET] == '0);
        end else begin : g_no_range
            assign in_range = 1'b1;
        end
    endgenerate

    // Every accepted request owns a FIFO slot from fire to pop, so the
    // in-flight stage can always push without checking for space.
    assign inflight_count = IW'(s1_valid_reg);
    assign credits_used   = (CW+1)'(fifo_count) + (CW+1)'(inflight_count);
    assign req_ready      = !reset && (credits_used < (CW+1)'(RSP_DEPTH));
    assign fire           = req_valid && req_ready;

    // Write strobes are gated by reset so the macro sees a clean idle state.
    assign wr_en      = req_we && !reset;
    assign sram_csb0  = !(fire && in_range);
    assign sram_web0  = !wr_en;
    assign sram_addr0 = req_addr[ADDR_WIDTH+BYTE_OFFSET-1:BYTE_OFFSET];
    assign sram_din0  = req_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WMASKS; gi++) begin : g_lane
            assign sram_wmask0[gi] = wr_en && req_wmask[gi];
        end
    endgenerate

    // Capture stage: the macro registers the access at the end of the fire
    // cycle and drives dout mid-way through this one.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_we_reg    <= 1'b0;
            s1_err_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= fire;
            s1_we_reg    <= req_we;
            s1_err_reg   <= !in_range;
        end
    end

    assign cap_rdata = (s1_we_reg || s1_err_reg) ? '0 : sram_dout0;
    assign push_data = {cap_rdata, s1_we_reg, s1_err_reg};

    sync_fifo #(
        .WIDTH (RW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (s1_valid_reg),
        .push_data (push_data),
        .pop       (rsp_pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty && !reset;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign {rsp_rdata, rsp_we, rsp_err} = head;

    assign unused_bits = ^{req_addr[BYTE_OFFSET-1:0], fifo_full};

endmodule

// File: tb/tb_sram_port_adapter.sv
// Scoreboard bench for sram_port_adapter with a behavioural model of the
// registered-input SRAM macro (read/write at the negedge after capture).
module tb_sram_port_adapter;
    import nucleusrv_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_wmask = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_we;
    logic        rsp_err;
    logic        sram_csb0;
    logic        sram_web0;
    logic [3:0]  sram_wmask0;
    logic [24:0] sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0 = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_count = 0;
    int last_rsp_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    mem_rsp_t    exp_q[$];
    logic [31:0] model_mem [256];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sram_port_adapter dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_wmask   (req_wmask),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_we      (rsp_we),
        .rsp_err     (rsp_err),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    // SRAM macro model
    logic [31:0] sram_mem [256];
    logic        q_csb = 1'b1;
    logic        q_web = 1'b1;
    logic [3:0]  q_wmask = '0;
    logic [24:0] q_addr = '0;
    logic [31:0] q_din = '0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram_mem[i]  = '0;
            model_mem[i] = '0;
        end
    end

    always @(posedge clock) begin
        q_csb   <= sram_csb0;
        q_web   <= sram_web0;
        q_wmask <= sram_wmask0;
        q_addr  <= sram_addr0;
        q_din   <= sram_din0;
    end

    always @(negedge clock) begin
        if (!q_csb) begin
            if (!q_web) begin
                for (int b = 0; b < 4; b++)
                    if (q_wmask[b]) sram_mem[q_addr[7:0]][8*b +: 8] = q_din[8*b +: 8];
            end else begin
                sram_dout0 <= sram_mem[q_addr[7:0]];
            end
        end
    end

    // Response monitor: pops the scoreboard on every handshake
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            mem_rsp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stale_rsp: got rdata=%h we=%b err=%b, required no response", rsp_rdata, rsp_we, rsp_err);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_rdata, rsp_we, rsp_err} !== {e.rdata, e.we, e.err}) begin
                    errors++;
                    $display("FAIL rsp_data: got rdata=%h we=%b err=%b, required rdata=%h we=%b err=%b",
                             rsp_rdata, rsp_we, rsp_err, e.rdata, e.we, e.err);
                end else begin
                    $display("rsp cyc=%0d rdata=%h we=%b err=%b", cyc, rsp_rdata, rsp_we, rsp_err);
                end
            end
            rsp_count++;
            last_rsp_cyc = cyc;
            last_rdata = rsp_rdata;
            last_err = rsp_err;
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, output int fcyc);
        bit done = 0;
        bit ok;
        mem_rsp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wmask = mask;
        req_wdata = data;
        fcyc = -1;
        ok = (addr[31:27] == 5'd0);
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clock);
            if (req_ready) begin
                checks++;
                if (sram_csb0 !== !ok) begin
                    errors++;
                    $display("FAIL csb0: addr=%h got %b, required %b", addr, sram_csb0, !ok);
                end
                if (!ok) begin
                    e = '{rdata: 32'h0, we: we, err: 1'b1};
                end else if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (mask[b]) model_mem[addr[9:2]][8*b +: 8] = data[8*b +: 8];
                    e = '{rdata: 32'h0, we: 1'b1, err: 1'b0};
                end else begin
                    e = '{rdata: model_mem[addr[9:2]], we: 1'b0, err: 1'b0};
                end
                exp_q.push_back(e);
                $display("req cyc=%0d we=%b addr=%h mask=%h wdata=%h", cyc, we, addr, mask, data);
                fcyc = cyc;
                done = 1;
            end
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: addr=%h not accepted, required acceptance", addr);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        req_valid = 1'b1; req_we = 1'b1; req_wmask = 4'hF; req_addr = 32'h10;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks += 5;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b, required 0", req_ready); end
        if (sram_csb0 !== 1'b1) begin errors++; $display("FAIL rst_csb0: got %b, required 1", sram_csb0); end
        if (sram_web0 !== 1'b1) begin errors++; $display("FAIL rst_web0: got %b, required 1", sram_web0); end
        if (sram_wmask0 !== 4'h0) begin errors++; $display("FAIL rst_wmask0: got %h, required 0", sram_wmask0); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b, required 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_rsp_valid: got %b, required 0", rsp_valid); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_write_read();
        int f0, f1;
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, f0);
        issue(1'b0, 32'h10, 4'h0, 32'h0, f1);
        drain();
        checks += 3;
        if (f1 - f0 !== 1) begin errors++; $display("FAIL wr_rd_b2b: read fired %0d cycles after write, required 1", f1 - f0); end
        if (last_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data: got %h, required deadbeef", last_rdata); end
        if (last_rsp_cyc - f1 !== 2) begin errors++; $display("FAIL rd_latency: got %0d, required 2", last_rsp_cyc - f1); end
    endtask

    task automatic test_byte_mask();
        int f;
        issue(1'b1, 32'h20, 4'hF, 32'hAAAAAAAA, f);
        issue(1'b1, 32'h20, 4'b0101, 32'h11223344, f);
        issue(1'b0, 32'h20, 4'h0, 32'h0, f);
        drain();
        checks++;
        if (last_rdata !== 32'hAA22AA44) begin errors++; $display("FAIL byte_mask: got %h, required aa22aa44", last_rdata); end
    endtask

    task automatic test_out_of_range();
        int f;
        int base = rsp_count;
        issue(1'b0, 32'h10, 4'h0, 32'h0, f);
        issue(1'b0, 32'h20, 4'h0, 32'h0, f);
        issue(1'b0, 32'h0800_0000, 4'h0, 32'h0, f);
        drain();
        checks += 3;
        if (rsp_count - base !== 3) begin errors++; $display("FAIL oor_count: got %0d, required 3", rsp_count - base); end
        if (last_err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b, required 1", last_err); end
        if (last_rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h, required 0", last_rdata); end
    endtask

    task automatic test_back_pressure();
        int f, f0, f3, base;
        for (int i = 0; i < 6; i++) issue(1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hC0DE_0000 + 32'(i), f);
        drain();
        base = rsp_count;
        rsp_ready = 1'b0;
        issue(1'b0, 32'h100, 4'h0, 32'h0, f0);
        issue(1'b0, 32'h104, 4'h0, 32'h0, f);
        issue(1'b0, 32'h108, 4'h0, 32'h0, f);
        issue(1'b0, 32'h10C, 4'h0, 32'h0, f3);
        checks++;
        if (f3 - f0 !== 3) begin errors++; $display("FAIL bp_accept4: spread %0d cycles, required 3", f3 - f0); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h110;
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: cycle %0d req_ready=%b, required 0", t, req_ready); end
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        issue(1'b0, 32'h110, 4'h0, 32'h0, f);
        issue(1'b0, 32'h114, 4'h0, 32'h0, f);
        drain();
        checks++;
        if (rsp_count - base !== 6) begin errors++; $display("FAIL bp_count: got %0d, required 6", rsp_count - base); end
    endtask

    task automatic test_throughput();
        int f, first, last;
        first = 0; last = 0;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 32'h100 + 32'(4*(i % 6)), 4'h0, 32'h0, f);
            if (i == 0) first = f;
            last = f;
        end
        drain();
        checks += 2;
        if (last - first !== 15) begin errors++; $display("FAIL tput_fires: 16 fires spanned %0d cycles, required 15", last - first); end
        if (last_rsp_cyc - first !== 17) begin errors++; $display("FAIL tput_last_rsp: got %0d, required 17", last_rsp_cyc - first); end
    endtask

    task automatic test_reset_midstream();
        int f;
        issue(1'b0, 32'h10, 4'h0, 32'h0, f);
        issue(1'b0, 32'h20, 4'h0, 32'h0, f);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        checks += 2;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp_valid: got %b, required 0", rsp_valid); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b, required 0", req_ready); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready_after: got %b, required 1", req_ready); end
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_stale: cycle %0d rsp_valid=%b, required 0", t, rsp_valid); end
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        issue(1'b0, 32'h20, 4'h0, 32'h0, f);
        drain();
        checks++;
        if (last_rdata !== 32'hAA22AA44) begin errors++; $display("FAIL post_rst_read: got %h, required aa22aa44", last_rdata); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_out_of_range();
        test_back_pressure();
        test_throughput();
        test_reset_midstream();
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
